// File: rtl/instruction_cache_pkg.sv
// rtl/instruction_cache_pkg.sv - shared sizes and FSM encodings for the instruction cache
package instruction_cache_pkg;

    localparam int WORD_SIZE  = 16;
    localparam int LINE_WORDS = 4;
    localparam int LINE_SIZE  = 64;

    localparam logic [1:0] ST_LOOKUP      = 2'd0;
    localparam logic [1:0] ST_MISS_WAIT   = 2'd1;
    localparam logic [1:0] ST_REFILL_DONE = 2'd2;

endpackage

// File: rtl/instruction_cache_line_array.sv
// rtl/instruction_cache_line_array.sv - valid/tag/data storage with combinational read and synchronous write
module icache_line_array
    import instruction_cache_pkg::*;
#(
    parameter int NUM_LINES = 4,
    parameter int IDX_W     = 2,
    parameter int TAG_W     = 12
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic [IDX_W-1:0]     rd_index,
    output logic                 rd_valid,
    output logic [TAG_W-1:0]     rd_tag,
    output logic [LINE_SIZE-1:0] rd_data,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_index,
    input  logic [TAG_W-1:0]     wr_tag,
    input  logic [LINE_SIZE-1:0] wr_data
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_SIZE-1:0] data_q [NUM_LINES];

    // Only the valid bits are cleared; tag and data are don't-care until revalidated.
    always_ff @(posedge clk) begin
        if (clear) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !clear) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/instruction_cache.sv
// rtl/instruction_cache.sv - direct-mapped read-only instruction cache with hit/miss counters
module instruction_cache
    import instruction_cache_pkg::*;
#(
    parameter int NUM_LINES = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_read,
    input  logic [15:0]          cpu_addr,
    output logic [15:0]          cpu_data,
    output logic                 cpu_ready,
    output logic                 mem_req,
    output logic [15:0]          mem_addr,
    input  logic                 mem_ack,
    input  logic [LINE_SIZE-1:0] mem_rdata,
    output logic [15:0]          hit_count,
    output logic [15:0]          miss_count
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 16 - IDX_W - 2;

    logic [1:0]           state;
    logic                 rd_valid;
    logic [TAG_W-1:0]     rd_tag;
    logic [LINE_SIZE-1:0] rd_data;
    logic                 hit;
    logic                 miss;
    logic                 fill;
    logic [WORD_SIZE-1:0] word;

    icache_line_array #(
        .NUM_LINES(NUM_LINES),
        .IDX_W    (IDX_W),
        .TAG_W    (TAG_W)
    ) u_lines (
        .clk     (clk),
        .clear   (reset),
        .rd_index(cpu_addr[IDX_W+1:2]),
        .rd_valid(rd_valid),
        .rd_tag  (rd_tag),
        .rd_data (rd_data),
        .wr_en   (fill),
        .wr_index(mem_addr[IDX_W+1:2]),
        .wr_tag  (mem_addr[15:IDX_W+2]),
        .wr_data (mem_rdata)
    );

    always_comb begin
        word = '0;
        for (int w = 0; w < LINE_WORDS; w++) begin
            if (cpu_addr[1:0] == w[1:0]) begin
                word = rd_data[w*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

    // Reset forces ready low even though the FSM state only changes at the edge.
    assign hit       = (state == ST_LOOKUP) && !reset && cpu_read && rd_valid
                       && (rd_tag == cpu_addr[15:IDX_W+2]);
    assign miss      = (state == ST_LOOKUP) && !reset && cpu_read && !hit;
    assign fill      = (state == ST_MISS_WAIT) && !reset && mem_ack;
    assign cpu_ready = hit;
    assign cpu_data  = hit ? word : 16'h0000;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_LOOKUP;
            mem_req  <= 1'b0;
            mem_addr <= 16'h0000;
        end else begin
            case (state)
                ST_LOOKUP: begin
                    if (miss) begin
                        state    <= ST_MISS_WAIT;
                        mem_req  <= 1'b1;
                        mem_addr <= {cpu_addr[15:2], 2'b00};
                    end
                end
                ST_MISS_WAIT: begin
                    if (mem_ack) begin
                        state   <= ST_REFILL_DONE;
                        mem_req <= 1'b0;
                    end
                end
                default: state <= ST_LOOKUP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= 16'h0000;
            miss_count <= 16'h0000;
        end else begin
            if (hit && hit_count != 16'hFFFF) begin
                hit_count <= hit_count + 16'd1;
            end
            if (miss && miss_count != 16'hFFFF) begin
                miss_count <= miss_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_cache.sv
// tb/tb_instruction_cache.sv - scoreboard bench for instruction_cache
module tb_instruction_cache;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_read;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_data;
    logic        cpu_ready;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] exp_data_q[$];
    logic [15:0] exp_addr_q[$];

    instruction_cache #(.NUM_LINES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_read  (cpu_read),
        .cpu_addr  (cpu_addr),
        .cpu_data  (cpu_data),
        .cpu_ready (cpu_ready),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .hit_count (hit_count),
        .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every served word and every new line request is matched against the scoreboard.
    initial begin
        logic req_prev;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (cpu_ready === 1'b1) begin
                if (exp_data_q.size() == 0) check("unexpected_hit", {48'h0, cpu_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                else check("cpu_data", {48'h0, cpu_data}, {48'h0, exp_data_q.pop_front()});
            end
            if (mem_req === 1'b1 && req_prev !== 1'b1) begin
                if (exp_addr_q.size() == 0) check("unexpected_mem_req", {48'h0, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
                else check("mem_addr", {48'h0, mem_addr}, {48'h0, exp_addr_q.pop_front()});
            end
            req_prev = mem_req;
        end
    end

    task automatic hit(input logic [15:0] addr, input logic [15:0] exp);
        cpu_read = 1'b1;
        cpu_addr = addr;
        exp_data_q.push_back(exp);
        tick();
    endtask

    // Miss in the current cycle, ack after lat cycles of MISS_WAIT, return in the first LOOKUP cycle.
    task automatic miss(input logic [15:0] addr, input logic [15:0] line, input logic [63:0] data, input int lat);
        cpu_read = 1'b1;
        cpu_addr = addr;
        exp_addr_q.push_back(line);
        tick();
        check("mem_req_after_miss", {63'h0, mem_req}, 64'h1);
        repeat (lat) tick();
        mem_ack   = 1'b1;
        mem_rdata = data;
        tick();
        mem_ack = 1'b0;
        check("refill_done_not_ready", {63'h0, cpu_ready}, 64'h0);
        tick();
    endtask

    task automatic counters(input string name, input logic [15:0] hc, input logic [15:0] mc);
        check({name, "_hit_count"}, {48'h0, hit_count}, {48'h0, hc});
        check({name, "_miss_count"}, {48'h0, miss_count}, {48'h0, mc});
    endtask

    initial begin
        reset = 1'b1; cpu_read = 1'b1; cpu_addr = 16'h0000;
        mem_ack = 1'b0; mem_rdata = '0;
        tick(); tick();
        check("ready_during_reset", {63'h0, cpu_ready}, 64'h0);
        reset = 1'b0; cpu_read = 1'b0;
        check("reset_mem_req", {63'h0, mem_req}, 64'h0);
        check("reset_mem_addr", {48'h0, mem_addr}, 64'h0);
        check("reset_cpu_data", {48'h0, cpu_data}, 64'h0);
        counters("reset", 16'd0, 16'd0);

        // Cold miss then hits
        miss(16'h0000, 16'h0000, 64'h0004_0003_0002_0001, 3);
        hit(16'h0000, 16'd1); hit(16'h0001, 16'd2); hit(16'h0002, 16'd3); hit(16'h0003, 16'd4);
        cpu_read = 1'b0;
        counters("cold", 16'd4, 16'd1);

        // Conflict on index 0
        miss(16'h0010, 16'h0010, 64'h1111_2222_3333_4444, 0);
        hit(16'h0010, 16'h4444);
        miss(16'h0001, 16'h0000, 64'h0004_0003_0002_0001, 1);
        hit(16'h0001, 16'd2);
        cpu_read = 1'b0;
        counters("conflict", 16'd6, 16'd3);

        // Reset during MISS_WAIT, stale ack afterwards
        cpu_read = 1'b1; cpu_addr = 16'h0020;
        exp_addr_q.push_back(16'h0020);
        tick();
        check("mid_miss_req", {63'h0, mem_req}, 64'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0; cpu_read = 1'b0;
        check("mid_miss_reset_req", {63'h0, mem_req}, 64'h0);
        check("mid_miss_reset_addr", {48'h0, mem_addr}, 64'h0);
        counters("mid_miss", 16'd0, 16'd0);
        tick();
        mem_ack = 1'b1; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        tick();
        mem_ack = 1'b0;

        // 0x0020 misses; address moves to 0x0005 before the ack
        cpu_read = 1'b1; cpu_addr = 16'h0020;
        exp_addr_q.push_back(16'h0020);
        tick();
        cpu_addr = 16'h0005;
        tick();
        check("addr_change_req_held", {63'h0, mem_req}, 64'h1);
        check("addr_change_mem_addr", {48'h0, mem_addr}, 64'h0020);
        mem_ack = 1'b1; mem_rdata = 64'h2004_2003_2002_2001;
        tick();
        mem_ack = 1'b0;
        tick();
        miss(16'h0005, 16'h0004, 64'h3004_3003_3002_3001, 2);
        hit(16'h0005, 16'h3002);
        hit(16'h0020, 16'h2001);
        cpu_read = 1'b0;
        counters("addr_change", 16'd2, 16'd2);

        // Idle with a stale ack in LOOKUP
        for (int i = 0; i < 10; i++) begin
            mem_ack   = (i == 3);
            mem_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
            tick();
        end
        mem_ack = 1'b0;
        check("idle_mem_req", {63'h0, mem_req}, 64'h0);
        counters("idle", 16'd2, 16'd2);
        hit(16'h0005, 16'h3002);
        hit(16'h0020, 16'h2001);

        // Saturation
        for (int i = 0; i < 65540; i++) hit(16'h0021, 16'h2002);
        cpu_read = 1'b0;
        tick();
        counters("saturate", 16'hFFFF, 16'd2);

        check("pending_data_empty", exp_data_q.size(), 64'h0);
        check("pending_addr_empty", exp_addr_q.size(), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
